latch_bank_write_scheduler: RTL and testbench
=============================================

Name: latch_bank_write_scheduler

Overview:
Sequences writes into a bank of level-sensitive D-latch registers (the CPU register file storage) and shares its single write port between two requesters. Requesters are ALU writeback on port 0 and load unit on port 1.
- Arbitrates round-robin between them.
- Drives common latch data and a one-hot latch gate per write.
- Uses a fixed setup/gate/hold sequence so D is stable around the gate pulse.

Parameters:
NUM_REGS, 6, number of latch registers in the bank (1..2^ADDR_W)
ADDR_W, 3, register address width
DATA_W, 16, latch data width

Ports:
CLK  input  1  system clock, rising-edge
RST  input  1  synchronous active-high reset
req0_valid  input  1  requester 0 has a write pending
req0_addr  input  ADDR_W  requester 0 target register
req0_data  input  DATA_W  requester 0 write data
req0_ready  output  1  requester 0 write accepted this cycle when valid
req1_valid  input  1  requester 1 has a write pending
req1_addr  input  ADDR_W  requester 1 target register
req1_data  input  DATA_W  requester 1 write data
req1_ready  output  1  requester 1 write accepted this cycle when valid
lat_d  output  DATA_W  data bus to all latch D inputs
lat_en  output  NUM_REGS  one-hot latch gate (CLK input of each latch)
busy  output  1  write sequence in progress (state != IDLE)
last_grant  output  1  index of most recently accepted requester

Behaviour:
- Clock and reset: single clock CLK; reset RST is synchronous and active-high.
- Reset values: state=IDLE, lat_d=0, lat_en=0, busy=0, last_grant=1, so port 0 wins the first contention. Ready outputs are 0 while RST=1.
- FSM states: IDLE -> SETUP -> GATE -> HOLD -> IDLE. Each phase lasts 1 cycle.
- Write cost: 3 cycles per write, plus 1 IDLE cycle between writes, so peak throughput is 1 write per 4 cycles.
- Arbitration is in IDLE only, and ready is combinational:
  - Single valid requester: it wins.
  - Both valid: the requester != last_grant wins.
  - reqN_ready = (state==IDLE) & !RST & (winner==N). Never both ready at once.
- Accept occurs on a cycle with valid&&ready. On that edge:
  - addr and data are captured into internal registers.
  - last_grant is updated.
  - state -> SETUP.
- Requesters may change addr/data freely after acceptance.
- lat_d is driven from the captured data in SETUP, GATE and HOLD. In IDLE, lat_d holds its last value and does not follow inputs.
- lat_en[addr]=1 in GATE only, registered output, exactly 1 cycle wide. All other lat_en bits are 0 at all times.
- Out-of-range address (addr >= NUM_REGS): the write is accepted and sequenced normally, but no lat_en bit asserts in GATE, so the bank is unchanged.
- A valid deasserted before acceptance is no error. No request is queued.
- Reset mid-sequence: on the RST edge lat_en drops to 0 and state -> IDLE. The in-flight write is abandoned; a partial gate is acceptable only if reset arrives in GATE.

Optional Feature:
LBWS_OOB_ERR_EN
- Defined: adds output port err_oob (1 bit, reset 0). err_oob pulses high for exactly the GATE cycle of any write whose address >= NUM_REGS.
- Undefined: port absent; out-of-range writes are dropped silently as above.

Decomposition:
- Package lbws_pkg:
  - state enum lbws_state_t {IDLE, SETUP, GATE, HOLD}
  - localparam GRANT_RESET=1'b1
- Sub-module rr_arbiter2: combinational 2-way round-robin. Inputs are valids, last_grant and an enable (state==IDLE); outputs are one-hot grant and winner index.
- The top level holds the FSM, capture registers and one-hot address decode.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, no valids -> lat_en=0, busy=0, last_grant=1, lat_d=0, both readies 0 during reset.
- Single write: req0 valid, addr=2, data=16'hA5A5 -> req0_ready=1 that cycle; then SETUP (lat_d=A5A5, lat_en=0), GATE (lat_en=6'b000100), HOLD (lat_en=0, lat_d=A5A5); IDLE on cycle 4.
- Contention, both valid continuously after reset: req0 addr 1 data 1, req1 addr 3 data 3 -> grants alternate 0,1,0,1. lat_en pulses 000010, then 001000, spaced 4 cycles apart.
- Capture isolation: change req0_data to 16'hFFFF the cycle after acceptance of 16'h1234 -> lat_d remains 1234 through HOLD.
- Out-of-range address: addr=7, NUM_REGS=6 -> full 3-cycle sequence, busy=1, lat_en never nonzero. With LBWS_OOB_ERR_EN defined, err_oob=1 in the GATE cycle only.
- Reset in GATE: assert RST while lat_en=000100 -> next cycle lat_en=0, state IDLE, last_grant=1, a pending req0 is then granted cleanly.

Source files
------------

// File: rtl/latch_bank_write_scheduler_pkg.sv
// Shared types for the latch bank write scheduler: sequencer states and the
// arbitration reset value.
package lbws_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        GATE  = 2'd2,
        HOLD  = 2'd3
    } lbws_state_t;

    // Port 0 wins the first contention after reset.
    localparam logic GRANT_RESET = 1'b1;

endpackage

// File: rtl/latch_bank_write_scheduler_if.sv
// Requester handshakes and latch-bank drive signals of the write scheduler.
// err_oob exists only when LBWS_OOB_ERR_EN is defined.
interface latch_bank_write_scheduler_if #(
    parameter int NUM_REGS = 6,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 16
);
    logic                req0_valid;
    logic [ADDR_W-1:0]   req0_addr;
    logic [DATA_W-1:0]   req0_data;
    logic                req0_ready;
    logic                req1_valid;
    logic [ADDR_W-1:0]   req1_addr;
    logic [DATA_W-1:0]   req1_data;
    logic                req1_ready;
    logic [DATA_W-1:0]   lat_d;
    logic [NUM_REGS-1:0] lat_en;
    logic                busy;
    logic                last_grant;
`ifdef LBWS_OOB_ERR_EN
    logic                err_oob;
`endif

    modport master (
`ifdef LBWS_OOB_ERR_EN
        input  err_oob,
`endif
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  lat_d, lat_en, busy, last_grant
    );

    modport slave (
`ifdef LBWS_OOB_ERR_EN
        output err_oob,
`endif
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output lat_d, lat_en, busy, last_grant
    );

endinterface

// File: rtl/latch_bank_write_scheduler_rr_arbiter2.sv
// Combinational two-way round-robin arbiter: on contention the requester that
// did not win last time is granted; grant is one-hot and only when enabled.
module rr_arbiter2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    input  logic       en_i,
    output logic [1:0] grant_o,
    output logic       winner_o
);

    // Pick the winner and qualify the grant with its valid and the enable.
    always_comb begin
        winner_o = last_grant_i;
        grant_o  = 2'b00;
        if (en_i) begin
            if (valid_i == 2'b11) begin
                winner_o = ~last_grant_i;
            end else if (valid_i[1]) begin
                winner_o = 1'b1;
            end else if (valid_i[0]) begin
                winner_o = 1'b0;
            end else begin
                winner_o = last_grant_i;
            end
            grant_o = valid_i & (winner_o ? 2'b10 : 2'b01);
        end else begin
            grant_o = 2'b00;
        end
    end

endmodule

// File: rtl/latch_bank_write_scheduler.sv
// Shares the single latch-bank write port between two requesters with a fixed
// SETUP/GATE/HOLD sequence. Optional feature macro: LBWS_OOB_ERR_EN (err_oob).
module latch_bank_write_scheduler
    import lbws_pkg::*;
#(
    parameter int NUM_REGS = 6,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    latch_bank_write_scheduler_if.slave  bus
);

    lbws_state_t         state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   lat_d_q, lat_d_d;
    logic [NUM_REGS-1:0] lat_en_q, lat_en_d;
    logic                busy_q, busy_d;
    logic                last_grant_q, last_grant_d;
    logic                err_oob_q, err_oob_d;
    logic [1:0]          grant_s;
    logic                winner_s;
    logic                arb_en_s;
    logic                in_range_s;

    assign arb_en_s = (state_q == IDLE) && !RST;

    rr_arbiter2 u_arb (
        .valid_i      ({bus.req1_valid, bus.req0_valid}),
        .last_grant_i (last_grant_q),
        .en_i         (arb_en_s),
        .grant_o      (grant_s),
        .winner_o     (winner_s)
    );

    // Next state, capture of the winning request and registered latch drive.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        lat_d_d      = lat_d_q;
        last_grant_d = last_grant_q;
        lat_en_d     = '0;
        case (state_q)
            IDLE: begin
                if (grant_s != 2'b00) begin
                    state_d      = SETUP;
                    addr_d       = winner_s ? bus.req1_addr : bus.req0_addr;
                    lat_d_d      = winner_s ? bus.req1_data : bus.req0_data;
                    last_grant_d = winner_s;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP:   state_d = GATE;
            GATE:    state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Out-of-range addresses run the sequence but never open a gate.
        in_range_s = int'(addr_d) < NUM_REGS;
        for (int i = 0; i < NUM_REGS; i++) begin
            lat_en_d[i] = (state_d == GATE) && in_range_s && (int'(addr_d) == i);
        end
        busy_d    = (state_d != IDLE);
        err_oob_d = (state_d == GATE) && !in_range_s;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            lat_d_q      <= '0;
            lat_en_q     <= '0;
            busy_q       <= 1'b0;
            last_grant_q <= GRANT_RESET;
            err_oob_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            lat_d_q      <= lat_d_d;
            lat_en_q     <= lat_en_d;
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
            err_oob_q    <= err_oob_d;
        end
    end

    assign bus.req0_ready = grant_s[0];
    assign bus.req1_ready = grant_s[1];
    assign bus.lat_d      = lat_d_q;
    assign bus.lat_en     = lat_en_q;
    assign bus.busy       = busy_q;
    assign bus.last_grant = last_grant_q;
`ifdef LBWS_OOB_ERR_EN
    assign bus.err_oob    = err_oob_q;
`else
    logic unused_err_oob_s;
    assign unused_err_oob_s = err_oob_q;
`endif

endmodule

// File: tb/tb_latch_bank_write_scheduler.sv
// Self-checking bench for latch_bank_write_scheduler: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_latch_bank_write_scheduler;

    localparam int NR = 6;
    localparam int AW = 3;
    localparam int DW = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   errors = 0;
    int   checks = 0;

    latch_bank_write_scheduler_if #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    latch_bank_write_scheduler #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        RST = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0 got=%b exp=0", bus.req0_ready); end
            checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1 got=%b exp=0", bus.req1_ready); end
        end
        next_cycle();
        idle_inputs();
        RST = 1'b0;
        @(negedge CLK);
        checks++; if (bus.lat_en !== 6'b000000) begin errors++; $display("FAIL reset_lat_en got=%b exp=000000", bus.lat_en); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.last_grant !== 1'b1) begin errors++; $display("FAIL reset_last_grant got=%b exp=1", bus.last_grant); end
        checks++; if (bus.lat_d !== 16'h0000) begin errors++; $display("FAIL reset_lat_d got=%h exp=0000", bus.lat_d); end
        next_cycle();
    endtask

    task automatic test_single_write();
        bus.req0_valid = 1'b1; bus.req0_addr = 3'd2; bus.req0_data = 16'hA5A5;
        @(negedge CLK);
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready0 got=%b exp=1", bus.req0_ready); end
        checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready1 got=%b exp=0", bus.req1_ready); end
        next_cycle();
        idle_inputs();
        @(negedge CLK);
        checks++; if (bus.lat_d !== 16'hA5A5 || bus.lat_en !== 6'b000000 || bus.busy !== 1'b1) begin errors++; $display("FAIL single_setup got d=%h en=%b busy=%b exp d=a5a5 en=000000 busy=1", bus.lat_d, bus.lat_en, bus.busy); end
        next_cycle(); @(negedge CLK);
        checks++; if (bus.lat_en !== 6'b000100 || bus.lat_d !== 16'hA5A5) begin errors++; $display("FAIL single_gate got en=%b d=%h exp en=000100 d=a5a5", bus.lat_en, bus.lat_d); end
        next_cycle(); @(negedge CLK);
        checks++; if (bus.lat_en !== 6'b000000 || bus.lat_d !== 16'hA5A5 || bus.busy !== 1'b1) begin errors++; $display("FAIL single_hold got en=%b d=%h busy=%b", bus.lat_en, bus.lat_d, bus.busy); end
        next_cycle(); @(negedge CLK);
        checks++; if (bus.busy !== 1'b0 || bus.lat_d !== 16'hA5A5 || bus.last_grant !== 1'b0) begin errors++; $display("FAIL single_idle got busy=%b d=%h lg=%b exp busy=0 d=a5a5 lg=0", bus.busy, bus.lat_d, bus.last_grant); end
        next_cycle();
    endtask

    task automatic test_contention();
        int grants[$];
        int pulse_cyc[$];
        logic [5:0] pulse_val[$];
        RST = 1'b1;
        next_cycle();
        RST = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_addr = 3'd1; bus.req0_data = 16'd1;
        bus.req1_valid = 1'b1; bus.req1_addr = 3'd3; bus.req1_data = 16'd3;
        for (int c = 0; c < 16; c++) begin
            @(negedge CLK);
            checks++; if (bus.req0_ready && bus.req1_ready) begin errors++; $display("FAIL contention_both_ready cycle=%0d got=11 exp=one-hot", c); end
            if (bus.req0_ready) grants.push_back(0);
            if (bus.req1_ready) grants.push_back(1);
            if (bus.lat_en != 6'b0) begin pulse_cyc.push_back(c); pulse_val.push_back(bus.lat_en); end
            next_cycle();
        end
        idle_inputs();
        checks++; if (grants.size() != 4) begin errors++; $display("FAIL contention_grant_count got=%0d exp=4", grants.size()); end
        for (int i = 0; i < grants.size() && i < 4; i++) begin
            checks++; if (grants[i] != (i % 2)) begin errors++; $display("FAIL contention_grant%0d got=%0d exp=%0d", i, grants[i], i % 2); end
        end
        checks++; if (pulse_cyc.size() != 4) begin errors++; $display("FAIL contention_pulse_count got=%0d exp=4", pulse_cyc.size()); end
        for (int i = 0; i < pulse_cyc.size() && i < 4; i++) begin
            checks++; if (pulse_val[i] !== ((i % 2 == 0) ? 6'b000010 : 6'b001000) || pulse_cyc[i] != 2 + 4 * i) begin
                errors++; $display("FAIL contention_pulse%0d got en=%b cyc=%0d exp en=%b cyc=%0d", i, pulse_val[i], pulse_cyc[i], (i % 2 == 0) ? 6'b000010 : 6'b001000, 2 + 4 * i);
            end
        end
        repeat (4) next_cycle();
    endtask

    task automatic test_capture_isolation();
        bus.req0_valid = 1'b1; bus.req0_addr = 3'd0; bus.req0_data = 16'h1234;
        @(negedge CLK);
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL capture_ready got=%b exp=1", bus.req0_ready); end
        next_cycle();
        bus.req0_valid = 1'b0; bus.req0_data = 16'hFFFF; bus.req0_addr = 3'd5;
        for (int p = 0; p < 3; p++) begin
            @(negedge CLK);
            checks++; if (bus.lat_d !== 16'h1234) begin errors++; $display("FAIL capture_lat_d phase=%0d got=%h exp=1234", p, bus.lat_d); end
            checks++; if (bus.lat_en !== ((p == 1) ? 6'b000001 : 6'b000000)) begin errors++; $display("FAIL capture_lat_en phase=%0d got=%b", p, bus.lat_en); end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_out_of_range();
        bus.req1_valid = 1'b1; bus.req1_addr = 3'd7; bus.req1_data = 16'hBEEF;
        @(negedge CLK);
        checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL oob_ready1 got=%b exp=1", bus.req1_ready); end
        next_cycle();
        idle_inputs();
        for (int p = 0; p < 3; p++) begin
            @(negedge CLK);
            checks++; if (bus.busy !== 1'b1 || bus.lat_en !== 6'b000000) begin errors++; $display("FAIL oob_phase%0d got busy=%b en=%b exp busy=1 en=000000", p, bus.busy, bus.lat_en); end
`ifdef LBWS_OOB_ERR_EN
            checks++; if (bus.err_oob !== (p == 1)) begin errors++; $display("FAIL oob_err phase=%0d got=%b exp=%b", p, bus.err_oob, p == 1); end
`endif
            next_cycle();
        end
        @(negedge CLK);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL oob_idle_busy got=%b exp=0", bus.busy); end
        next_cycle();
    endtask

    task automatic test_reset_in_gate();
        bus.req1_valid = 1'b1; bus.req1_addr = 3'd2; bus.req1_data = 16'h5555;
        next_cycle();
        idle_inputs();
        next_cycle();
        @(negedge CLK);
        checks++; if (bus.lat_en !== 6'b000100) begin errors++; $display("FAIL rgate_pre got=%b exp=000100", bus.lat_en); end
        RST = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_addr = 3'd4; bus.req0_data = 16'h7777;
        next_cycle();
        RST = 1'b0;
        @(negedge CLK);
        checks++; if (bus.lat_en !== 6'b000000 || bus.busy !== 1'b0 || bus.last_grant !== 1'b1) begin errors++; $display("FAIL rgate_after got en=%b busy=%b lg=%b exp 000000 0 1", bus.lat_en, bus.busy, bus.last_grant); end
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL rgate_regrant got=%b exp=1", bus.req0_ready); end
        next_cycle();
        idle_inputs();
        next_cycle(); @(negedge CLK);
        checks++; if (bus.lat_en !== 6'b010000 || bus.lat_d !== 16'h7777) begin errors++; $display("FAIL rgate_new_gate got en=%b d=%h exp 010000 7777", bus.lat_en, bus.lat_d); end
        repeat (3) next_cycle();
    endtask

    // Transaction-level reference: a write occupies three cycles after its
    // accept, gating only in the middle one; arbitration alternates on contention.
    task automatic test_random();
        int phase = 0;
        int lg = 1;
        int exp_a = 0;
        logic [15:0] exp_d = 16'h0000;
        logic [5:0]  exp_en;
        int w;
        RST = 1'b1;
        next_cycle();
        RST = 1'b0;
        phase = 0; lg = 1; exp_d = 16'h0000;
        for (int c = 0; c < 600; c++) begin
            RST = ($urandom_range(0, 49) == 0);
            bus.req0_valid = ($urandom_range(0, 2) != 0);
            bus.req1_valid = ($urandom_range(0, 2) != 0);
            bus.req0_addr  = 3'($urandom_range(0, 7));
            bus.req1_addr  = 3'($urandom_range(0, 7));
            bus.req0_data  = 16'($urandom);
            bus.req1_data  = 16'($urandom);
            w = -1;
            if (phase == 0 && !RST) begin
                if (bus.req0_valid && bus.req1_valid) w = 1 - lg;
                else if (bus.req0_valid) w = 0;
                else if (bus.req1_valid) w = 1;
            end
            exp_en = 6'b000000;
            if (phase == 2 && exp_a < NR) exp_en[exp_a] = 1'b1;
            @(negedge CLK);
            checks++; if (bus.req0_ready !== (w == 0) || bus.req1_ready !== (w == 1)) begin errors++; $display("FAIL rand_ready c=%0d got=%b%b exp=%b%b", c, bus.req1_ready, bus.req0_ready, w == 1, w == 0); end
            checks++; if (bus.busy !== (phase != 0)) begin errors++; $display("FAIL rand_busy c=%0d got=%b exp=%b", c, bus.busy, phase != 0); end
            checks++; if (bus.lat_en !== exp_en) begin errors++; $display("FAIL rand_lat_en c=%0d got=%b exp=%b", c, bus.lat_en, exp_en); end
            checks++; if (bus.lat_d !== exp_d) begin errors++; $display("FAIL rand_lat_d c=%0d got=%h exp=%h", c, bus.lat_d, exp_d); end
            checks++; if (bus.last_grant !== 1'(lg)) begin errors++; $display("FAIL rand_last_grant c=%0d got=%b exp=%0d", c, bus.last_grant, lg); end
`ifdef LBWS_OOB_ERR_EN
            checks++; if (bus.err_oob !== (phase == 2 && exp_a >= NR)) begin errors++; $display("FAIL rand_err_oob c=%0d got=%b", c, bus.err_oob); end
`endif
            if (RST) begin
                phase = 0; lg = 1; exp_d = 16'h0000; exp_a = 0;
            end else if (w >= 0) begin
                phase = 1; lg = w;
                exp_a = (w == 0) ? int'(bus.req0_addr) : int'(bus.req1_addr);
                exp_d = (w == 0) ? bus.req0_data : bus.req1_data;
            end else if (phase != 0) begin
                phase = (phase == 3) ? 0 : phase + 1;
            end
            next_cycle();
        end
        RST = 1'b0;
        idle_inputs();
        repeat (4) next_cycle();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_write();
        test_contention();
        test_capture_isolation();
        test_out_of_range();
        test_reset_in_gate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
